// File: rtl/ts_pkg.sv
// ts_pkg: shared constants and types for the MPEG-TS FIFO reader.
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } ts_state_t;

  typedef logic [7:0] ts_byte_t;

endpackage

// File: rtl/ts_bit_shifter.sv
// ts_bit_shifter: MSB-first 8-bit assembly register with bit count and full flag.
// A take and a shift in the same cycle leave the new bit as the first bit of the next byte.
module ts_bit_shifter
  import ts_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  input  logic       take,
  output ts_byte_t   data,
  output logic [3:0] count,
  output logic       full
);

  assign full = (count == 4'd8);

  // shift register and bit counter
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      if (shift_en) begin
        data <= {data[6:0], bit_in};
      end
      case ({take, shift_en})
        2'b11:   count <= 4'd1;
        2'b10:   count <= 4'd0;
        2'b01:   count <= count + 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ts_fifo_reader.sv
// ts_fifo_reader: read side of a 1-bit FIFO; finds MPEG-TS byte alignment and
// streams packet bytes with SOP/EOP markers over a valid/ready interface.
// Optional feature: define TS_SYNC_CHECK_EN to check the header byte of every
// packet while locked and drop back to HUNT on a mismatch.
//
// state | meaning
// HUNT  | 8-bit sliding window searches the bit stream for SYNC_BYTE
// LOCK  | byte aligned; bits assembled into bytes, packet index counted
module ts_fifo_reader
  import ts_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
  parameter int         PKT_LEN   = TS_PKT_LEN
) (
  input  logic     CLOCK,
  input  logic     RESET_N,
  input  logic     FIFO_Q,
  input  logic     FIFO_EMPTY,
  output logic     FIFO_RDREQ,
  output ts_byte_t BYTE_DATA,
  output logic     BYTE_VALID,
  input  logic     BYTE_READY,
  output logic     BYTE_SOP,
  output logic     BYTE_EOP,
  output logic     LOCKED,
  output logic     SYNC_ERR
);

  localparam int               IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  ts_state_t        state, state_next;
  logic             rd_pending;
  ts_byte_t         window, window_next, window_seed;
  logic [IDX_W-1:0] pkt_idx, idx_next;
  ts_byte_t         sh_data, load_data;
  logic [3:0]       sh_count;
  logic             sh_full, sh_take, sh_clear, sh_shift;
  logic             capture, drain, out_free;
  logic [4:0]       in_flight;
  logic             out_load, load_sop, load_eop;
  logic             sync_bad, sync_err, win_load;

  assign capture     = rd_pending;
  assign drain       = BYTE_VALID && BYTE_READY;
  assign out_free    = !BYTE_VALID || BYTE_READY;
  // bits held in the shifter, the output register and the one still in flight
  assign in_flight   = {1'b0, sh_count} + (BYTE_VALID ? 5'd8 : 5'd0) + {4'd0, rd_pending};
  assign window_next = capture ? {window[6:0], FIFO_Q} : window;
  // a rejected header seeds the window, plus any bit landing on the same edge
  assign window_seed = capture ? {sh_data[6:0], FIFO_Q} : sh_data;
  assign sh_shift    = capture && (state == LOCK);
  assign LOCKED      = (state == LOCK);
  assign SYNC_ERR    = sync_err;

  ts_bit_shifter u_shifter (
    .clk_sys  (CLOCK),
    .rst_b    (RESET_N),
    .clear    (sh_clear),
    .shift_en (sh_shift),
    .bit_in   (FIFO_Q),
    .take     (sh_take),
    .data     (sh_data),
    .count    (sh_count),
    .full     (sh_full)
  );

  // next state, read request and output-register load decisions
  always_comb begin
    state_next = state;
    FIFO_RDREQ = 1'b0;
    sh_take    = 1'b0;
    sh_clear   = 1'b0;
    out_load   = 1'b0;
    load_data  = sh_data;
    load_sop   = 1'b0;
    load_eop   = 1'b0;
    idx_next   = pkt_idx;
    sync_bad   = 1'b0;
    win_load   = 1'b0;
    case (state)
      HUNT: begin
        sh_clear   = 1'b1;
        FIFO_RDREQ = RESET_N && !FIFO_EMPTY && !BYTE_VALID;
        if ((window_next == SYNC_BYTE) && out_free) begin
          state_next = LOCK;
          out_load   = 1'b1;
          load_data  = window_next;
          load_sop   = 1'b1;
          load_eop   = (LAST_IDX == '0);
          idx_next   = '0;
        end
      end
      LOCK: begin
        FIFO_RDREQ = RESET_N && !FIFO_EMPTY && (in_flight < 5'd16);
        if (sh_full && out_free) begin
          sh_take  = 1'b1;
          idx_next = (pkt_idx == LAST_IDX) ? '0 : pkt_idx + IDX_W'(1);
`ifdef TS_SYNC_CHECK_EN
          sync_bad = (idx_next == '0) && (sh_data != SYNC_BYTE);
`else
          sync_bad = 1'b0;
`endif
          if (sync_bad) begin
            state_next = HUNT;
            win_load   = 1'b1;
          end else begin
            out_load = 1'b1;
            load_sop = (idx_next == '0);
            load_eop = (idx_next == LAST_IDX);
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // request tracking, hunt window, packet index and output register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pending <= 1'b0;
      window     <= '0;
      pkt_idx    <= '0;
      BYTE_DATA  <= '0;
      BYTE_VALID <= 1'b0;
      BYTE_SOP   <= 1'b0;
      BYTE_EOP   <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      rd_pending <= FIFO_RDREQ;
      sync_err   <= sync_bad;
      pkt_idx    <= idx_next;
      if (win_load) begin
        window <= window_seed;
      end else if (state == HUNT) begin
        window <= window_next;
      end
      if (out_load) begin
        BYTE_DATA  <= load_data;
        BYTE_VALID <= 1'b1;
        BYTE_SOP   <= load_sop;
        BYTE_EOP   <= load_eop;
      end else if (drain) begin
        BYTE_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ts_fifo_reader.sv
// tb_ts_fifo_reader: scoreboard bench for ts_fifo_reader (behaviour under
// TS_SYNC_CHECK_EN follows the same define).
module tb_ts_fifo_reader;

  logic       CLOCK      = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       FIFO_Q     = 1'b0;
  logic       FIFO_EMPTY = 1'b1;
  logic       FIFO_RDREQ;
  logic [7:0] BYTE_DATA;
  logic       BYTE_VALID;
  logic       BYTE_READY = 1'b0;
  logic       BYTE_SOP;
  logic       BYTE_EOP;
  logic       LOCKED;
  logic       SYNC_ERR;

  int         checks     = 0;
  int         errors     = 0;
  int         out_cnt    = 0;
  int         err_pulses = 0;
  int         lock_falls = 0;
  logic       bit_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] exp_head;
  bit         stall      = 1'b0;
  bit         take       = 1'b0;
  logic       locked_d   = 1'b0;

  ts_fifo_reader dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .FIFO_Q     (FIFO_Q),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RDREQ (FIFO_RDREQ),
    .BYTE_DATA  (BYTE_DATA),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY),
    .BYTE_SOP   (BYTE_SOP),
    .BYTE_EOP   (BYTE_EOP),
    .LOCKED     (LOCKED),
    .SYNC_ERR   (SYNC_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) bit_q.push_back(b[i]);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_it, input bit sop, input bit eop);
    push_bits(b, 8);
    if (expect_it) exp_q.push_back({sop, eop, b});
  endtask

  task automatic wait_cnt(input int target, input int budget, input string name);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    check(name, 32'(out_cnt >= target), 1);
  endtask

  task automatic wait_locked(input int budget, input string name);
    int n = 0;
    while (!LOCKED && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    check(name, 32'(LOCKED), 1);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (20) @(negedge CLOCK);
  endtask

  // FIFO model: a request sampled at edge k presents its bit after edge k
  always begin
    @(negedge CLOCK);
    take = FIFO_RDREQ;
    @(posedge CLOCK);
    #2;
    if (take && bit_q.size() > 0) FIFO_Q = bit_q.pop_front();
    FIFO_EMPTY = (bit_q.size() == 0) || stall;
  end

  // monitor: compares every accepted byte against the scoreboard
  always @(negedge CLOCK) begin
    if (RESET_N) begin
      if (SYNC_ERR) err_pulses++;
      if (locked_d && !LOCKED) lock_falls++;
      if (BYTE_VALID && BYTE_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h sop %0d eop %0d expected none",
                   BYTE_DATA, BYTE_SOP, BYTE_EOP);
        end else begin
          exp_head = exp_q.pop_front();
          check("byte_sop_eop_data", {22'd0, BYTE_SOP, BYTE_EOP, BYTE_DATA}, {22'd0, exp_head});
        end
        out_cnt++;
      end
    end
    locked_d = LOCKED;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         stable;
    bit         have;
    logic [9:0] snap;

    // stream for acquisition, stall and backpressure: 101, packet 1, start of packet 2
    push_bits(8'b101, 3);
    push_byte(8'h47, 1, 1, 0);
    for (int i = 0; i < 187; i++) push_byte(8'(i), 1, 0, i == 186);
    push_byte(8'h47, 1, 1, 0);
    push_byte(8'h00, 1, 0, 0);
    push_byte(8'h01, 1, 0, 0);

    @(posedge CLOCK);
    repeat (3) begin
      @(negedge CLOCK);
      check("reset_outputs",
            {18'd0, FIFO_RDREQ, BYTE_VALID, BYTE_SOP, BYTE_EOP, LOCKED, SYNC_ERR, BYTE_DATA}, 0);
    end
    check("reset_fifo_nonempty", 32'(FIFO_EMPTY), 0);

    @(posedge CLOCK);
    #1;
    RESET_N    = 1'b1;
    BYTE_READY = 1'b1;
    wait_locked(300, "locked_rise");

    wait_cnt(10, 2000, "reach_stall");
    @(posedge CLOCK);
    #1;
    for (int i = 0; i < 20; i++) begin
      stall = !stall;
      repeat (3) @(posedge CLOCK);
      #1;
    end
    stall = 1'b0;

    wait_cnt(40, 2000, "reach_backpressure");
    @(posedge CLOCK);
    #1;
    BYTE_READY = 1'b0;
    stable     = 1'b1;
    have       = 1'b0;
    snap       = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK);
      if (BYTE_VALID) begin
        if (!have) begin
          snap = {BYTE_SOP, BYTE_EOP, BYTE_DATA};
          have = 1'b1;
        end else if ({BYTE_SOP, BYTE_EOP, BYTE_DATA} !== snap) begin
          stable = 1'b0;
        end
      end
    end
    check("bp_valid_held", 32'(BYTE_VALID), 1);
    check("bp_output_stable", 32'(stable), 1);
    check("bp_fifo_nonempty", 32'(FIFO_EMPTY), 0);
    check("bp_rdreq_off", 32'(FIFO_RDREQ), 0);
    @(posedge CLOCK);
    #1;
    BYTE_READY = 1'b1;
    drain(4000, "drain_acquire");
    check("count_acquire", out_cnt, 191);

    // rest of packet 2, interrupted by reset at packet index 90
    @(posedge CLOCK);
    #1;
    for (int i = 2; i < 187; i++) push_byte(8'(i), 1, 0, i == 186);
    wait_cnt(279, 3000, "reach_index_90");
    @(posedge CLOCK);
    #1;
    BYTE_READY = 1'b0;
    repeat (10) @(negedge CLOCK);
    check("pre_reset_valid", 32'(BYTE_VALID), 1);
    check("pre_reset_locked", 32'(LOCKED), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_clear", {22'd0, BYTE_VALID, LOCKED, BYTE_DATA}, 0);
    repeat (3) @(posedge CLOCK);
    #1;
    bit_q.delete();
    exp_q.delete();

    // relock stream: 11, packet 1, packet 2 with a bad header, packet 3 start
    push_bits(8'b11, 2);
    push_byte(8'h47, 1, 1, 0);
    for (int i = 0; i < 187; i++) push_byte(8'(i), 1, 0, i == 186);
`ifdef TS_SYNC_CHECK_EN
    push_byte(8'h46, 0, 0, 0);
    for (int i = 0; i < 187; i++) push_byte(8'h00, 0, 0, 0);
`else
    push_byte(8'h46, 1, 1, 0);
    for (int i = 0; i < 187; i++) push_byte(8'h00, 1, 0, i == 186);
`endif
    push_byte(8'h47, 1, 1, 0);
    push_byte(8'h11, 1, 0, 0);
    push_byte(8'h22, 1, 0, 0);
    push_byte(8'h33, 1, 0, 0);
    err_pulses = 0;
    lock_falls = 0;
    out_cnt    = 0;
    BYTE_READY = 1'b1;
    RESET_N    = 1'b1;

    wait_locked(300, "relock_after_reset");
    drain(9000, "drain_sync");
    check("locked_end", 32'(LOCKED), 1);
`ifdef TS_SYNC_CHECK_EN
    check("sync_err_pulses", err_pulses, 1);
    check("lock_falls", lock_falls, 1);
    check("count_sync", out_cnt, 192);
`else
    check("sync_err_pulses", err_pulses, 0);
    check("lock_falls", lock_falls, 0);
    check("count_sync", out_cnt, 380);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_fifo_reader.md
TS_FIFO_READER -- requirements
Module: ts_fifo_reader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h47, MPEG-TS sync pattern.
REQ-002 SHALL have parameter PKT_LEN, default 188, bytes per TS packet.
REQ-003 SHALL have ports:
- CLOCK  input  1  single clock.
- RESET_N  input  1  asynchronous, active-low reset.
- FIFO_Q  input  1  1-bit FIFO read data, valid the cycle after a sampled FIFO_RDREQ.
- FIFO_EMPTY  input  1  FIFO read-side empty.
- FIFO_RDREQ  output  1  FIFO read request.
- BYTE_DATA  output  8  assembled byte.
- BYTE_VALID  output  1  BYTE_DATA valid.
- BYTE_READY  input  1  downstream accepts; transfer when VALID and READY are both high.
- BYTE_SOP  output  1  byte is packet index 0.
- BYTE_EOP  output  1  byte is packet index PKT_LEN-1.
- LOCKED  output  1  packet alignment acquired.
- SYNC_ERR  output  1  one-cycle pulse on sync loss.

Function
REQ-004 SHALL be the read side of the 1-bit dual-clock FIFO and treat the FIFO as normal mode: a bit requested at edge k SHALL be captured from FIFO_Q at edge k+1.
REQ-005 SHALL track rd_pending, high when a request was sampled at the previous edge.
REQ-006 SHALL use states HUNT and LOCK; reset state is HUNT.
REQ-007 Bit order SHALL be MSB first: each new bit shifts in at bit 0.
REQ-008 In HUNT, FIFO_RDREQ SHALL be !FIFO_EMPTY && !BYTE_VALID.
- Each captured bit shifts an 8-bit sliding window.
- When the window equals SYNC_BYTE, the FSM SHALL move to LOCK and load the window into the output register with BYTE_SOP=1 and packet index 0.
- BYTE_VALID SHALL rise in the cycle after the edge that captured the matching bit.
REQ-009 In LOCK, FIFO_RDREQ SHALL be !FIFO_EMPTY && (shift_cnt + 8*BYTE_VALID + rd_pending < 16).
- This limit guarantees no in-flight bit is ever lost.
REQ-010 In LOCK, a completed 8-bit shift byte SHALL move to the output register on the edge where the register is empty or being drained (VALID && READY).
- Otherwise the byte SHALL wait in the shift register.
REQ-011 The packet index SHALL increment per byte loaded and wrap from PKT_LEN-1 to 0.
- BYTE_SOP SHALL be high at index 0.
- BYTE_EOP SHALL be high at index PKT_LEN-1.
REQ-012 BYTE_DATA, BYTE_SOP and BYTE_EOP SHALL stay stable while BYTE_VALID && !BYTE_READY.
REQ-013 FIFO_EMPTY high SHALL simply stall capture; the partial shift count SHALL be retained.
REQ-014 A capture and an output transfer in the same edge SHALL both take effect.
REQ-015 LOCKED SHALL equal (state==LOCK).

Reset
REQ-016 RESET_N low SHALL immediately clear all of the following: FIFO_RDREQ, BYTE_DATA=8'h00, BYTE_VALID, BYTE_SOP, BYTE_EOP, LOCKED, SYNC_ERR, rd_pending, the shift register and count, the window, and the packet index; state SHALL be HUNT.
REQ-017 Reset in mid-packet SHALL discard buffered bits; re-hunting SHALL start on the first edge after RESET_N rises.

Configuration
REQ-018 With TS_SYNC_CHECK_EN defined, every byte at index 0 in LOCK SHALL be compared to SYNC_BYTE. On a mismatch:
- the byte SHALL NOT be output;
- SYNC_ERR SHALL pulse for 1 cycle;
- the FSM SHALL return to HUNT with the window preloaded with that byte.
REQ-019 Without TS_SYNC_CHECK_EN, SYNC_ERR SHALL be constant 0, and LOCK SHALL be left only by reset.

Structure
REQ-020 Package ts_pkg SHALL hold TS_SYNC_BYTE, TS_PKT_LEN, the state enum (HUNT, LOCK) and the 8-bit byte typedef.
REQ-021 Sub-module ts_bit_shifter SHALL implement the MSB-first 8-bit shift register with bit count and full flag.

Verification
REQ-022 Reset: hold RESET_N low for 3 cycles with FIFO non-empty -> every output is 0 and FIFO_RDREQ stays 0.
REQ-023 Acquire: feed bits 101, then 0x47, then 187 bytes 0x00..0xBA with BYTE_READY=1.
- LOCKED rises.
- The first byte is 0x47 with SOP=1.
- Byte 188 is 0xBA with EOP=1.
- Then SOP=1 again on the next 0x47.
REQ-024 Backpressure: hold BYTE_READY low for 40 cycles in LOCK.
- FIFO_RDREQ drops once 16 bits are held.
- After release, the byte sequence is contiguous and no bits are lost.
REQ-025 Empty stall: toggle FIFO_EMPTY every 3 cycles mid-byte -> the bytes assembled are identical to those from an unstalled run.
REQ-026 TS_SYNC_CHECK_EN defined and the second packet header is 0x46:
- SYNC_ERR pulses once.
- LOCKED falls.
- 0x46 is not output.
- LOCKED re-rises on the next 0x47.
- Without the macro, the same stream outputs 0x46 with SOP=1.
REQ-027 Reset mid-packet at byte 90 -> BYTE_VALID clears asynchronously, and the reader relocks on the next sync after release.
